// File: rtl/fifo_dualport_flags.sv
// Show-ahead synchronous FIFO: a registered-read dual-port SRAM with a bypass register and a prefetch read.
// Optional sticky overflow/underflow flags are built when FIFO_STICKY_ERR_EN is defined.

module sram_dualport #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

module fifo_dualport_flags #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 8,
  parameter int AE_LEVEL = 1,
  parameter int AF_LEVEL = DEPTH - 1
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       wr_en_i,
  input  logic                       rd_en_i,
  input  logic [WIDTH-1:0]           data_i,
  output logic [WIDTH-1:0]           data_o,
  output logic                       empty_o,
  output logic                       full_o,
  output logic                       almost_empty_o,
  output logic                       almost_full_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       overflow_o,
  output logic                       underflow_o
);
  localparam int W_PTR = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW    = $clog2(DEPTH + 1);
  localparam logic [W_PTR-1:0] LAST = W_PTR'(DEPTH - 1);
  localparam logic [CW-1:0]    AE_L = CW'(AE_LEVEL);
  localparam logic [CW-1:0]    AF_L = CW'(AF_LEVEL);

  logic [W_PTR:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]    count;
  logic             bypass_valid;
  logic [WIDTH-1:0] bypass_data;
  logic [WIDTH-1:0] sram_out;
  logic [W_PTR-1:0] rd_next_idx;
  logic             empty, full, push, pop, one, load_bypass, sram_re;

  function automatic logic [W_PTR:0] ptr_inc(input logic [W_PTR:0] p);
    if (p[W_PTR-1:0] == LAST) return {~p[W_PTR], {W_PTR{1'b0}}};
    else                      return {p[W_PTR], p[W_PTR-1:0] + 1'b1};
  endfunction

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[W_PTR-1:0] == rd_ptr[W_PTR-1:0]) && (wr_ptr[W_PTR] != rd_ptr[W_PTR]);
  assign push  = wr_en_i && (!full || rd_en_i);
  assign pop   = rd_en_i && !empty;
  assign one   = (count == CW'(1));

  // The head word bypasses the SRAM when it would otherwise arrive a cycle late.
  assign load_bypass = push && (empty || (one && pop));
  // Prefetch the word behind the head; with one entry there is nothing behind it.
  assign sram_re     = pop && !one;
  assign rd_next_idx = (rd_ptr[W_PTR-1:0] == LAST) ? '0 : rd_ptr[W_PTR-1:0] + 1'b1;

  sram_dualport #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(W_PTR)) u_sram (
    .clk   (clk_i),
    .we    (push),
    .waddr (wr_ptr[W_PTR-1:0]),
    .wdata (data_i),
    .re    (sram_re),
    .raddr (rd_next_idx),
    .rdata (sram_out)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      bypass_valid <= 1'b0;
      bypass_data  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (load_bypass) begin
        bypass_valid <= 1'b1;
        bypass_data  <= data_i;
      end else if (pop) begin
        bypass_valid <= 1'b0;
      end
    end
  end

  assign empty_o        = empty;
  assign full_o         = full;
  assign count_o        = count;
  assign almost_empty_o = (count <= AE_L);
  assign almost_full_o  = (count >= AF_L);
  assign data_o         = empty ? '0 : (bypass_valid ? bypass_data : sram_out);

`ifdef FIFO_STICKY_ERR_EN
  logic overflow, underflow;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_en_i && full && !rd_en_i) overflow  <= 1'b1;
      if (rd_en_i && empty)            underflow <= 1'b1;
    end
  end

  assign overflow_o  = overflow;
  assign underflow_o = underflow;
`else
  assign overflow_o  = 1'b0;
  assign underflow_o = 1'b0;
`endif
endmodule
